// File: rtl/chart_playback_sequencer_if.sv
// Chart storage read bus shared by the playback sequencer (master) and chart storage (slave).
interface chart_playback_sequencer_if #(
  parameter int NOTE_WIDTH = 9
);
  logic [7:0]            read_chart_id;
  logic [15:0]           chart_note_cnt;
  logic [7:0]            note_rd_idx;
  logic [NOTE_WIDTH-1:0] note_rd_data;

  modport master (
    output read_chart_id,
    output note_rd_idx,
    input  chart_note_cnt,
    input  note_rd_data
  );

  modport slave (
    input  read_chart_id,
    input  note_rd_idx,
    output chart_note_cnt,
    output note_rd_data
  );
endinterface

// File: rtl/chart_playback_sequencer.sv
// Chart playback sequencer: loads a chart header, prefetches notes and steps one slot per period.
// Optional macro PLAYBACK_LOOP_EN: wrap to slot 0 at chart end instead of finishing.
module chart_playback_sequencer #(
  parameter int NOTE_WIDTH  = 9,
  parameter int CHART_LEN   = 200,
  parameter int STEP_CYCLES = 12500000,
  parameter int READ_LAT    = 3
) (
  input  logic                      clk,
  input  logic                      sys_rst,
  input  logic                      start,
  input  logic [7:0]                chart_id,
  input  logic                      stop,
  input  logic                      pause,
  chart_playback_sequencer_if.master store,
  output logic [NOTE_WIDTH-1:0]     cur_note,
  output logic [NOTE_WIDTH-1:0]     next_note,
  output logic [7:0]                note_idx,
  output logic                      step,
  output logic                      playing,
  output logic                      done
);

  localparam int DIV_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int LD_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(STEP_CYCLES - 1);
  localparam logic [LD_W-1:0]  LD_LAST   = LD_W'(READ_LAT - 1);
  localparam logic [7:0]       CHART_MAX = 8'(CHART_LEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FETCH0 = 3'd2,
    S_FETCH1 = 3'd3,
    S_PLAY   = 3'd4,
    S_PAUSE  = 3'd5
  } state_t;

  state_t                state_r, state_s;
  logic [7:0]            rd_id_r, rd_id_s;
  logic [LD_W-1:0]       ld_cnt_r, ld_cnt_s;
  logic [7:0]            cnt_r, cnt_s;
  logic [7:0]            rd_idx_r, rd_idx_s;
  logic [NOTE_WIDTH-1:0] cur_r, cur_s;
  logic [NOTE_WIDTH-1:0] nxt_r, nxt_s;
  logic [7:0]            idx_r, idx_s;
  logic [DIV_W-1:0]      div_r, div_s;
  logic                  refill_r, refill_s;
  logic                  refill_ok_r, refill_ok_s;
  logic                  step_r, step_s;
  logic                  playing_r, playing_s;
  logic                  done_r, done_s;
  logic [7:0]            clamp_s;
  logic [7:0]            idx_inc_s;
  logic [7:0]            idx_nn_s;
`ifdef PLAYBACK_LOOP_EN
  logic [7:0]            nn_once_s;
  logic [7:0]            nn_wrap_s;
`endif

  // Next-state and next-output logic for the playback FSM.
  always_comb begin
    state_s     = state_r;
    rd_id_s     = rd_id_r;
    ld_cnt_s    = ld_cnt_r;
    cnt_s       = cnt_r;
    rd_idx_s    = rd_idx_r;
    cur_s       = cur_r;
    nxt_s       = nxt_r;
    idx_s       = idx_r;
    div_s       = div_r;
    refill_s    = 1'b0;
    refill_ok_s = refill_ok_r;
    step_s      = 1'b0;
    playing_s   = playing_r;
    done_s      = 1'b0;
    clamp_s     = (store.chart_note_cnt > 16'(CHART_LEN)) ? CHART_MAX : store.chart_note_cnt[7:0];
    idx_inc_s   = idx_r + 8'd1;
    idx_nn_s    = idx_r + 8'd2;
`ifdef PLAYBACK_LOOP_EN
    // Slot index two ahead, modulo the chart length (two folds cover cnt==1).
    nn_once_s   = (idx_nn_s >= cnt_r) ? (idx_nn_s - cnt_r) : idx_nn_s;
    nn_wrap_s   = (nn_once_s >= cnt_r) ? (nn_once_s - cnt_r) : nn_once_s;
`endif

    if (stop && (state_r != S_IDLE)) begin
      state_s     = S_IDLE;
      rd_id_s     = 8'd0;
      ld_cnt_s    = '0;
      cnt_s       = 8'd0;
      rd_idx_s    = 8'd0;
      cur_s       = '0;
      nxt_s       = '0;
      idx_s       = 8'd0;
      div_s       = '0;
      refill_ok_s = 1'b0;
      playing_s   = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && (chart_id != 8'd0)) begin
            rd_id_s  = chart_id;
            ld_cnt_s = '0;
            state_s  = S_LOAD;
          end else begin
            state_s  = S_IDLE;
          end
        end
        S_LOAD: begin
          if (ld_cnt_r == LD_LAST) begin
            cnt_s   = clamp_s;
            rd_id_s = 8'd0;
            if (clamp_s == 8'd0) begin
              done_s  = 1'b1;
              state_s = S_IDLE;
            end else begin
              rd_idx_s = 8'd0;
              state_s  = S_FETCH0;
            end
          end else begin
            ld_cnt_s = ld_cnt_r + LD_W'(1);
          end
        end
        S_FETCH0: begin
          cur_s    = store.note_rd_data;
          rd_idx_s = 8'd1;
          state_s  = S_FETCH1;
        end
        S_FETCH1: begin
          if (cnt_r == 8'd1) begin
`ifdef PLAYBACK_LOOP_EN
            nxt_s = cur_r;
`else
            nxt_s = '0;
`endif
          end else begin
            nxt_s = store.note_rd_data;
          end
          state_s   = S_PLAY;
          step_s    = 1'b1;
          idx_s     = 8'd0;
          div_s     = '0;
          playing_s = 1'b1;
        end
        S_PLAY, S_PAUSE: begin
          // The prefetch issued on the last step completes even if pause just rose.
          if (refill_r) begin
            nxt_s = refill_ok_r ? store.note_rd_data : '0;
          end else begin
            nxt_s = nxt_r;
          end
          if (pause) begin
            state_s = S_PAUSE;
          end else begin
            state_s = S_PLAY;
            if (div_r == DIV_LAST) begin
              div_s = '0;
              if (idx_inc_s < cnt_r) begin
                idx_s    = idx_inc_s;
                cur_s    = nxt_r;
                step_s   = 1'b1;
                refill_s = 1'b1;
`ifdef PLAYBACK_LOOP_EN
                rd_idx_s    = nn_wrap_s;
                refill_ok_s = 1'b1;
`else
                rd_idx_s    = idx_nn_s;
                refill_ok_s = (idx_nn_s < cnt_r);
`endif
              end else begin
`ifdef PLAYBACK_LOOP_EN
                idx_s       = 8'd0;
                cur_s       = nxt_r;
                step_s      = 1'b1;
                refill_s    = 1'b1;
                rd_idx_s    = nn_wrap_s;
                refill_ok_s = 1'b1;
`else
                cur_s     = '0;
                done_s    = 1'b1;
                playing_s = 1'b0;
                state_s   = S_IDLE;
`endif
              end
            end else begin
              div_s = div_r + DIV_W'(1);
            end
          end
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_r     <= S_IDLE;
      rd_id_r     <= 8'd0;
      ld_cnt_r    <= '0;
      cnt_r       <= 8'd0;
      rd_idx_r    <= 8'd0;
      cur_r       <= '0;
      nxt_r       <= '0;
      idx_r       <= 8'd0;
      div_r       <= '0;
      refill_r    <= 1'b0;
      refill_ok_r <= 1'b0;
      step_r      <= 1'b0;
      playing_r   <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      rd_id_r     <= rd_id_s;
      ld_cnt_r    <= ld_cnt_s;
      cnt_r       <= cnt_s;
      rd_idx_r    <= rd_idx_s;
      cur_r       <= cur_s;
      nxt_r       <= nxt_s;
      idx_r       <= idx_s;
      div_r       <= div_s;
      refill_r    <= refill_s;
      refill_ok_r <= refill_ok_s;
      step_r      <= step_s;
      playing_r   <= playing_s;
      done_r      <= done_s;
    end
  end

  assign store.read_chart_id = rd_id_r;
  assign store.note_rd_idx   = rd_idx_r;
  assign cur_note            = cur_r;
  assign next_note           = nxt_r;
  assign note_idx            = idx_r;
  assign step                = step_r;
  assign playing             = playing_r;
  assign done                = done_r;

endmodule

// File: tb/tb_chart_playback_sequencer.sv
// Directed bench for chart_playback_sequencer with a small chart-storage model (STEP_CYCLES=4, READ_LAT=3).
module tb_chart_playback_sequencer;
  logic       clk = 1'b0;
  logic       sys_rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic [7:0] chart_id;
  logic [8:0] cur_note;
  logic [8:0] next_note;
  logic [7:0] note_idx;
  logic       step;
  logic       playing;
  logic       done;
  logic [7:0] sel_chart;
  int         checks = 0;
  int         errors = 0;

  chart_playback_sequencer_if #(.NOTE_WIDTH(9)) ifc ();

  chart_playback_sequencer #(
    .NOTE_WIDTH(9), .CHART_LEN(200), .STEP_CYCLES(4), .READ_LAT(3)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .chart_id(chart_id),
    .stop(stop), .pause(pause), .store(ifc),
    .cur_note(cur_note), .next_note(next_note), .note_idx(note_idx),
    .step(step), .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  // Chart 1: C4,C4,G4,rest,A5.
  function automatic logic [8:0] note1(input int k);
    case (k)
      0: return 9'h001;
      1: return 9'h001;
      2: return 9'h008;
      3: return 9'h000;
      4: return 9'h020;
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [8:0] next1(input int k);
    if (k + 1 < 5) return note1(k + 1);
`ifdef PLAYBACK_LOOP_EN
    return note1(0);
`else
    return 9'h000;
`endif
  endfunction

  // Storage remembers the last requested chart; header and notes are combinational.
  always @(posedge clk) begin
    if (sys_rst) sel_chart <= 8'd0;
    else if (ifc.read_chart_id != 8'd0) sel_chart <= ifc.read_chart_id;
  end

  always_comb begin
    ifc.chart_note_cnt = 16'd0;
    ifc.note_rd_data   = 9'h000;
    case (sel_chart)
      8'd1: begin
        ifc.chart_note_cnt = 16'd5;
        ifc.note_rd_data   = note1(int'(ifc.note_rd_idx));
      end
      8'd2: ifc.chart_note_cnt = 16'd0;
      8'd3: begin
        ifc.chart_note_cnt = 16'd300;
        ifc.note_rd_data   = 9'(ifc.note_rd_idx) + 9'd1;
      end
      default: ;
    endcase
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_read"}, ifc.read_chart_id, 8'd0);
    check({tag, "_rdidx"}, ifc.note_rd_idx, 8'd0);
    check({tag, "_cur"}, cur_note, 9'h000);
    check({tag, "_next"}, next_note, 9'h000);
    check({tag, "_idx"}, note_idx, 8'd0);
    check({tag, "_step"}, step, 1'b0);
    check({tag, "_playing"}, playing, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    int e;
    int k;
    int nsteps;
    int last_idx;
    int done_edge;
    logic exp_step;
    logic exp_done;
    logic live;

    sys_rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; chart_id = 8'd0;
    cyc(); cyc();
    check_idle("reset");
    sys_rst = 1'b0;

    // Normal playback of chart 1; a stray start mid-play must be ignored.
    start = 1'b1; chart_id = 8'd1;
    cyc(); start = 1'b0; chart_id = 8'd0;
    check("t1_read_e0", ifc.read_chart_id, 8'd1);
    cyc(); check("t1_read_e1", ifc.read_chart_id, 8'd1);
    cyc(); check("t1_read_e2", ifc.read_chart_id, 8'd1);
    cyc(); check("t1_read_e3", ifc.read_chart_id, 8'd0);
    check("t1_done_e3", done, 1'b0);
    cyc(); check("t1_step_e4", step, 1'b0);
    check("t1_cur_e4", cur_note, 9'h001);
    cyc(); check("t1_step_e5", step, 1'b1);
    check("t1_idx_e5", note_idx, 8'd0);
    check("t1_cur_e5", cur_note, 9'h001);
    check("t1_next_e5", next_note, 9'h001);
    check("t1_playing_e5", playing, 1'b1);
    for (e = 6; e <= 28; e++) begin
      cyc();
      start = 1'b0; chart_id = 8'd0;
`ifdef PLAYBACK_LOOP_EN
      exp_step = ((e - 5) % 4 == 0);
      exp_done = 1'b0;
      k = ((e - 5) / 4) % 5;
      live = 1'b1;
`else
      exp_step = ((e - 5) % 4 == 0) && (e <= 21);
      exp_done = (e == 25);
      k = (e - 5) / 4;
      if (k > 4) k = 4;
      live = (e < 25);
`endif
      check("t1_step", step, exp_step);
      check("t1_done", done, exp_done);
      if (live && exp_step) begin
        check("t1_idx", note_idx, k);
        check("t1_cur", cur_note, note1(k));
      end
      if (live && ((e - 5) % 4 == 1)) check("t1_next", next_note, next1(k));
      if (live) check("t1_playing", playing, 1'b1);
      else begin
        check("t1_end_playing", playing, 1'b0);
        check("t1_end_cur", cur_note, 9'h000);
      end
      if (e == 9) begin start = 1'b1; chart_id = 8'd3; end
    end
    stop = 1'b1;
    cyc(); stop = 1'b0;
    check("t1_after_playing", playing, 1'b0);

    // start with chart_id 0 is ignored.
    start = 1'b1; chart_id = 8'd0;
    cyc(); start = 1'b0;
    for (e = 0; e < 5; e++) begin
      check("t2_read", ifc.read_chart_id, 8'd0);
      check("t2_playing", playing, 1'b0);
      cyc();
    end

    // Empty chart: done at end of LOAD, never a step.
    start = 1'b1; chart_id = 8'd2;
    cyc(); start = 1'b0; chart_id = 8'd0;
    check("t3_read_e0", ifc.read_chart_id, 8'd2);
    cyc(); cyc(); cyc();
    check("t3_done_e3", done, 1'b1);
    check("t3_read_e3", ifc.read_chart_id, 8'd0);
    check("t3_step_e3", step, 1'b0);
    for (e = 4; e < 10; e++) begin
      cyc();
      check("t3_step", step, 1'b0);
      check("t3_done", done, 1'b0);
      check("t3_playing", playing, 1'b0);
    end

    // Oversized chart clamps to 200 slots.
    start = 1'b1; chart_id = 8'd3;
    cyc(); start = 1'b0; chart_id = 8'd0;
    nsteps = 0; last_idx = -1; done_edge = -1;
    for (e = 1; e <= 806; e++) begin
      cyc();
      if ((done === 1'b1) && (done_edge < 0)) done_edge = e;
      if ((step === 1'b1) && (e <= 804)) begin
        check("t4_idx", note_idx, nsteps);
        check("t4_cur", cur_note, 9'(nsteps + 1));
        nsteps++;
        last_idx = int'(note_idx);
      end
    end
    check("t4_nsteps", nsteps, 200);
    check("t4_last_idx", last_idx, 199);
`ifdef PLAYBACK_LOOP_EN
    check("t4_done_edge", done_edge, -1);
`else
    check("t4_done_edge", done_edge, 805);
`endif
    stop = 1'b1;
    cyc(); stop = 1'b0;

    // Pause at divider 2 for 10 cycles, then stop on a divider wrap.
    start = 1'b1; chart_id = 8'd1;
    cyc(); start = 1'b0; chart_id = 8'd0;
    cyc(); cyc(); cyc(); cyc();
    cyc(); check("t5_step_e5", step, 1'b1);
    cyc(); cyc();
    pause = 1'b1;
    for (e = 8; e <= 17; e++) begin
      cyc();
      check("t5_frozen_step", step, 1'b0);
      check("t5_frozen_idx", note_idx, 8'd0);
      check("t5_frozen_cur", cur_note, 9'h001);
      check("t5_frozen_next", next_note, 9'h001);
      check("t5_frozen_playing", playing, 1'b1);
    end
    pause = 1'b0;
    cyc(); check("t5_step_e18", step, 1'b0);
    cyc(); check("t5_step_e19", step, 1'b1);
    check("t5_idx_e19", note_idx, 8'd1);
    check("t5_cur_e19", cur_note, 9'h001);
    cyc(); check("t5_next_e20", next_note, 9'h008);
    check("t5_step_e20", step, 1'b0);
    cyc(); cyc();
    stop = 1'b1;
    cyc(); stop = 1'b0;
    check_idle("t6_stop_wrap");
    cyc();
    check("t6_done_after", done, 1'b0);
    check("t6_playing_after", playing, 1'b0);

    // Reset in the middle of FETCH.
    start = 1'b1; chart_id = 8'd1;
    cyc(); start = 1'b0; chart_id = 8'd0;
    cyc(); cyc(); cyc(); cyc();
    check("t7_cur_pre", cur_note, 9'h001);
    check("t7_rdidx_pre", ifc.note_rd_idx, 8'd1);
    sys_rst = 1'b1;
    cyc(); sys_rst = 1'b0;
    check_idle("t7_rst");
    cyc(); cyc();
    check("t7_step_after", step, 1'b0);
    check("t7_playing_after", playing, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
